// File: rtl/wide_addsub_sequencer_pkg.sv
// rtl/wide_addsub_sequencer_pkg.sv - shared state and opcode encodings for the wide add/sub sequencer
package wide_addsub_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/wide_addsub_sequencer_if.sv
// rtl/wide_addsub_sequencer_if.sv - command and result handshake bundle for the wide add/sub sequencer
interface wide_addsub_sequencer_if #(
    parameter int WIDTH = 18,
    parameter int WORDS = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic                   cmd_cin;
    logic [WIDTH*WORDS-1:0] cmd_a;
    logic [WIDTH*WORDS-1:0] cmd_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH*WORDS-1:0] res_data;
    logic                   res_cout;

    modport master (
        output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_cout
    );
endinterface

// File: rtl/wide_addsub_sequencer_post_adder_sub.sv
// rtl/wide_addsub_sequencer_post_adder_sub.sv - one-word adder/subtractor with carry or borrow in and out
module post_adder_sub
    import wide_addsub_sequencer_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             opmode,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    logic [WIDTH:0] sum;

    // The extra top bit is the carry for add and goes high on underflow for subtract.
    always_comb begin
        sum = '0;
        if (opmode == OP_SUB) begin
            sum = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, cin};
        end else begin
            sum = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
        end
    end

    assign out  = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];
endmodule

// File: rtl/wide_addsub_sequencer.sv
// rtl/wide_addsub_sequencer.sv - WORDS x WIDTH add/subtract built from one shared word adder, LSW first
module wide_addsub_sequencer
    import wide_addsub_sequencer_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    wide_addsub_sequencer_if.slave     bus,
    output logic                       busy
);
    localparam int               IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic                   cmd_ready_c;
    logic                   res_valid_c;
    logic                   busy_c;

    logic [WIDTH*WORDS-1:0] a_q;
    logic [WIDTH*WORDS-1:0] b_q;
    logic                   op_q;
    logic                   carry_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WIDTH*WORDS-1:0] res_data_q;
    logic                   res_cout_q;

    logic [WIDTH-1:0]       word_out;
    logic                   word_cout;

    post_adder_sub #(.WIDTH(WIDTH)) u_post_adder_sub (
        .in1    (a_q[idx_q*WIDTH +: WIDTH]),
        .in2    (b_q[idx_q*WIDTH +: WIDTH]),
        .opmode (op_q),
        .cin    (carry_q),
        .out    (word_out),
        .cout   (word_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        res_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_c      = 1'b1;
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are frozen at accept so the producer may change cmd_* freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_data_q <= '0;
            res_cout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        a_q        <= bus.cmd_a;
                        b_q        <= bus.cmd_b;
                        op_q       <= bus.cmd_op;
                        carry_q    <= bus.cmd_cin;
                        idx_q      <= '0;
                        res_data_q <= '0;
                    end
                end
                ST_RUN: begin
                    res_data_q[idx_q*WIDTH +: WIDTH] <= word_out;
                    carry_q                          <= word_cout;
                    idx_q                            <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        res_cout_q <= word_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_q;
    assign bus.res_cout  = res_cout_q;
    assign busy          = busy_c;
endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// tb/tb_wide_addsub_sequencer.sv - directed and table-driven checks for the wide add/sub sequencer
module tb_wide_addsub_sequencer;
    localparam int WIDTH = 18;
    localparam int WORDS = 4;
    localparam int W     = WIDTH * WORDS;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    wide_addsub_sequencer_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    wide_addsub_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         op;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_d;
        logic         exp_c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W:0] golden(input logic op, input logic cin,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        if (op) return {1'b0, a} - {1'b0, b} - (W+1)'(cin);
        else    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic run_op(input logic op, input logic cin, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ack,
                          output logic [W-1:0] d, output logic co, output int lat);
        int n;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_cin   = cin;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '1;
        bus.cmd_b     = '1;
        bus.cmd_op    = ~op;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.res_valid && lat < 50);
        d  = bus.res_data;
        co = bus.res_cout;
        if (ack) begin
            bus.res_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.res_ready = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic         co;
        int           lat;
        logic [W-1:0] ra[3];
        logic [W-1:0] rb[3];
        logic         rop[3];
        logic         rcin[3];
        int           acc[3];
        int           issued;
        int           got;
        logic         take;
        logic [W:0]   g;

        vecs[0] = '{1'b0, 1'b0, 72'h3FFFF, 72'h1, 72'h40000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FFFF, 72'h1, 72'h0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 72'h0, 72'h1, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 72'h5, 72'h3, 72'h1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 72'h1, 72'h2, 72'h4, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 72'h80_0000_0000_0000_0000, 72'h1, 72'h7F_FFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 72'h12_3456_789A_BCDE_F012, 72'h01_1111_1111_1111_1111,
                    72'h13_4567_89AB_CDF0_0123, 1'b0};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_res_data", bus.res_data, 0);
        check("reset_res_cout", bus.res_cout, 0);
        check("reset_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b, 1'b1, d, co, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d_cout", i), co, vecs[i].exp_c);
            check($sformatf("vec%0d_latency", i), lat, 5);
        end

        // Backpressure: result must sit still while new commands knock on a busy block.
        run_op(1'b0, 1'b0, 72'h3FFFF, 72'h1, 1'b0, d, co, lat);
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = i[0];
            bus.cmd_a     = {8'($urandom), $urandom, $urandom};
            bus.cmd_b     = {8'($urandom), $urandom, $urandom};
            @(negedge clk);
            check("bp_res_data", bus.res_data, 72'h40000);
            check("bp_res_cout", bus.res_cout, 0);
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_busy", busy, 1);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("bp_after_res_valid", bus.res_valid, 0);
        check("bp_after_cmd_ready", bus.cmd_ready, 1);
        run_op(1'b1, 1'b1, 72'h5, 72'h3, 1'b1, d, co, lat);
        check("bp_next_data", d, 72'h1);
        check("bp_next_cout", co, 0);

        // Reset during the second RUN cycle discards the partial result.
        @(negedge clk);
        bus.cmd_op    = 1'b0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_a     = 72'h3_0000_0005;
        bus.cmd_b     = 72'h1_0000_0007;
        bus.cmd_valid = 1'b1;
        check("rst_pre_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready", bus.cmd_ready, 1);
        check("rst_mid_res_valid", bus.res_valid, 0);
        check("rst_mid_res_data", bus.res_data, 0);
        check("rst_mid_busy", busy, 0);
        run_op(1'b0, 1'b0, 72'h10, 72'h20, 1'b1, d, co, lat);
        check("rst_next_data", d, 72'h30);
        check("rst_next_cout", co, 0);

        // Back-to-back with valid and ready held high.
        for (int k = 0; k < 3; k++) begin
            ra[k]   = {8'($urandom), $urandom, $urandom};
            rb[k]   = {8'($urandom), $urandom, $urandom};
            rop[k]  = 1'(k % 2);
            rcin[k] = 1'($urandom);
            acc[k]  = 0;
        end
        issued = 0;
        got    = 0;
        @(negedge clk);
        bus.cmd_op    = rop[0];
        bus.cmd_cin   = rcin[0];
        bus.cmd_a     = ra[0];
        bus.cmd_b     = rb[0];
        bus.cmd_valid = 1'b1;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 100 && got < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.res_valid) begin
                g = golden(rop[got], rcin[got], ra[got], rb[got]);
                check($sformatf("b2b%0d_data", got), bus.res_data, g[W-1:0]);
                check($sformatf("b2b%0d_cout", got), bus.res_cout, g[W]);
                got++;
            end
            take = bus.cmd_ready && bus.cmd_valid;
            if (take) begin
                acc[issued] = cyc;
                issued++;
            end
            @(posedge clk);
            #1;
            if (take) begin
                if (issued < 3) begin
                    bus.cmd_op  = rop[issued];
                    bus.cmd_cin = rcin[issued];
                    bus.cmd_a   = ra[issued];
                    bus.cmd_b   = rb[issued];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("b2b_results", got, 3);
        check("b2b_gap01", acc[1] - acc[0], 6);
        check("b2b_gap12", acc[2] - acc[1], 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
